tdc_readout_ctrl: RTL and testbench

//  Digital controller and readout for the vernier delay line TDC. Launches start/stop

---
 rtl/tdc_readout_ctrl_if.sv | 17 +
 rtl/tdc_readout_ctrl.sv | 131 +++++++++++++
 tb/tb_tdc_readout_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_readout_ctrl_if.sv
// Result handshake bundle of the TDC readout controller.
//   result       accumulated code, held while result_valid is high
//   result_valid result available
//   result_ack   consumer accept (sampled only while result_valid is high)
//   overflow     sticky saturation flag for the current/last measurement
// RES_W must equal $clog2(N_TAPS+1)+AVG_LOG2 of the attached controller.
interface tdc_readout_ctrl_if #(
  parameter int RES_W = 6
);
  logic [RES_W-1:0] result;
  logic             result_valid;
  logic             result_ack;
  logic             overflow;

  modport master (output result, output result_valid, output overflow, input result_ack);
  modport slave  (input result, input result_valid, input overflow, output result_ack);
endinterface

// File: rtl/tdc_readout_ctrl.sv
// Controller/readout for the vernier delay line TDC.
// Launches start/stop edge pairs into the analog front end, resynchronises the
// thermometer taps, bubble-corrects and encodes them, and accumulates
// 2**AVG_LOG2 conversions into one result returned over valid/ack.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ena         block enable; low forces IDLE at the next edge
//   meas_req    request one result; only looked at in IDLE
//   term        raw asynchronous thermometer taps, bit0 = first stage
//   start_edge  start launch into diff_gen
//   stop_edge   stop launch into stop_buffer
//   busy        high outside IDLE
//   rd          result/result_valid/result_ack/overflow bundle
module tdc_readout_ctrl #(
  parameter int N_TAPS     = 8,
  parameter int STOP_DLY   = 1,
  parameter int SETTLE_CYC = 3,
  parameter int AVG_LOG2   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                meas_req,
  input  logic [N_TAPS-1:0]   term,
  output logic                start_edge,
  output logic                stop_edge,
  output logic                busy,
  tdc_readout_ctrl_if.master  rd
);
  localparam int CODE_W  = $clog2(N_TAPS + 1);
  localparam int RES_W   = CODE_W + AVG_LOG2;
  localparam int N_CONV  = 1 << AVG_LOG2;
  localparam int CNT_W   = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int TMR_MAX = (STOP_DLY > SETTLE_CYC) ? STOP_DLY : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, STOP, CAPTURE, REARM, DONE} state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr;
  logic [CNT_W-1:0]   cnt;
  logic [RES_W-1:0]   acc;
  logic               ovf;
  logic [N_TAPS-1:0]  sync1, sync2;

  // Two-flop synchroniser; the decoder only ever sees stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= term;
      sync2 <= sync1;
    end
  end

  // Bubble correction: 3-input majority over neighbours, with the line edges
  // padded as t[-1]=1 (before the first stage) and t[N_TAPS]=0 (past the end).
  logic [N_TAPS+1:0] t_ext;
  logic [N_TAPS-1:0] t_fix;
  logic [CODE_W-1:0] code;
  logic              sat;

  assign t_ext = {1'b0, sync2, 1'b1};

  for (genvar i = 0; i < N_TAPS; i++) begin : g_maj
    assign t_fix[i] = (t_ext[i] & t_ext[i+1]) | (t_ext[i] & t_ext[i+2]) |
                      (t_ext[i+1] & t_ext[i+2]);
  end

  always_comb begin
    code = '0;
    for (int i = 0; i < N_TAPS; i++) code = code + CODE_W'(t_fix[i]);
  end

  assign sat = (code == CODE_W'(N_TAPS));

  // State register; tmr counts cycles spent in the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) tmr <= '0;
      else                    tmr <= tmr + TMR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (meas_req) state_nxt = LAUNCH;
      LAUNCH:  if (tmr == TMR_W'(STOP_DLY - 1)) state_nxt = STOP;
      STOP:    if (tmr == TMR_W'(SETTLE_CYC - 1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (cnt == CNT_W'(N_CONV - 1)) ? DONE : REARM;
      REARM:   if (tmr == TMR_W'(SETTLE_CYC - 1)) state_nxt = LAUNCH;
      DONE:    if (rd.result_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!ena) state_nxt = IDLE;
  end

  // Accumulation. overflow survives the return to IDLE so the consumer can
  // still read it after acking; it is cleared only when a new measurement starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE) begin
      acc <= '0;
      cnt <= '0;
      if (state_nxt == LAUNCH) ovf <= 1'b0;
    end else if (state == CAPTURE && ena) begin
      acc <= acc + RES_W'(code);
      cnt <= cnt + CNT_W'(1);
      if (sat) ovf <= 1'b1;
    end
  end

  // Edges are decoded straight from the state so an async reset drops them at once.
  always_comb begin
    start_edge      = (state == LAUNCH) || (state == STOP) || (state == CAPTURE);
    stop_edge       = (state == STOP) || (state == CAPTURE);
    busy            = (state != IDLE);
    rd.result_valid = (state == DONE);
    rd.result       = (state == DONE) ? acc : '0;
    rd.overflow     = ovf;
  end
endmodule

// File: tb/tb_tdc_readout_ctrl.sv
module tb_tdc_readout_ctrl;
  localparam int N_TAPS = 8;
  localparam int SETTLE = 3;
  localparam int AVG    = 2;
  localparam int NCONV  = 1 << AVG;
  localparam int RES_W  = 4 + AVG;
  localparam int SD_A   = 1;
  localparam int SD_B   = 4;

  logic       clk = 0, rst_n = 0, ena = 0;
  logic       meas_req = 0, meas_req_b = 0, ack_a = 0;
  logic [7:0] term = '0;
  logic       start_a, stop_a, busy_a, start_b, stop_b, busy_b;

  tdc_readout_ctrl_if #(.RES_W(RES_W)) a_if ();
  tdc_readout_ctrl_if #(.RES_W(RES_W)) b_if ();
  assign a_if.result_ack = ack_a;
  assign b_if.result_ack = b_if.result_valid;

  tdc_readout_ctrl #(.N_TAPS(N_TAPS), .STOP_DLY(SD_A), .SETTLE_CYC(SETTLE), .AVG_LOG2(AVG)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .meas_req(meas_req), .term(term),
    .start_edge(start_a), .stop_edge(stop_a), .busy(busy_a), .rd(a_if));

  tdc_readout_ctrl #(.N_TAPS(N_TAPS), .STOP_DLY(SD_B), .SETTLE_CYC(SETTLE), .AVG_LOG2(AVG)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .meas_req(meas_req_b), .term(term),
    .start_edge(start_b), .stop_edge(stop_b), .busy(busy_b), .rd(b_if));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt = 0, pass_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: corrected tap i is 1 when at least two of (t[i-1], t[i], t[i+1])
  // are 1, with a 1 before the line and a 0 past its end; code counts them.
  function automatic int ref_code(input logic [7:0] t);
    int c = 0;
    for (int i = 0; i < N_TAPS; i++) begin
      int l, r;
      l = (i == 0) ? 1 : int'(t[i-1]);
      r = (i == N_TAPS - 1) ? 0 : int'(t[i+1]);
      if (l + int'(t[i]) + r >= 2) c++;
    end
    return c;
  endfunction

  function automatic int lat(input int sd);
    return NCONV * (sd + SETTLE + 1) + (NCONV - 1) * SETTLE + 1;
  endfunction

  typedef struct { int res; int ovf; int req_cyc; } exp_t;
  exp_t sb[$];

  // Scoreboard monitor for instance A: one comparison set per rising valid.
  logic va_q = 0;
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_if.result_valid && !va_q) begin
      if (sb.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("result", int'(a_if.result), e.res);
        check("overflow", int'(a_if.overflow), e.ovf);
        check("latency", cyc - e.req_cyc, lat(SD_A));
      end
    end
    va_q <= a_if.result_valid;
  end

  // start_edge must lead stop_edge by STOP_DLY clocks.
  logic sa_q = 0, pa_q = 0, sb_q = 0, pb_q = 0;
  int   sa_cyc = 0, sb_cyc = 0;
  always @(negedge clk) begin
    if (start_a && !sa_q) sa_cyc <= cyc;
    if (stop_a && !pa_q)  check("lead_a", cyc - sa_cyc, SD_A);
    if (start_b && !sb_q) sb_cyc <= cyc;
    if (stop_b && !pb_q)  check("lead_b", cyc - sb_cyc, SD_B);
    sa_q <= start_a; pa_q <= stop_a; sb_q <= start_b; pb_q <= stop_b;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_a && n < 300) begin @(negedge clk); n++; end
    if (busy_a) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_valid_a(output bit ok);
    int n = 0;
    while (!a_if.result_valid && n < 300) begin @(negedge clk); n++; end
    ok = a_if.result_valid;
    if (!ok) check("valid_timeout", 1, 0);
  endtask

  task automatic issue_a(input logic [7:0] t);
    exp_t e;
    int   c;
    wait_idle();
    term = t;
    repeat (3) @(negedge clk);
    c = ref_code(t);
    e.res = c * NCONV; e.ovf = (c == N_TAPS) ? 1 : 0; e.req_cyc = cyc;
    sb.push_back(e);
    meas_req = 1;
    @(negedge clk);
    meas_req = 0;
  endtask

  // pre=1: ack already high when valid rises; else ack after dly cycles.
  task automatic do_meas(input logic [7:0] t, input bit pre, input int dly);
    bit ok;
    ack_a = pre;
    issue_a(t);
    wait_valid_a(ok);
    if (ok) begin
      if (!pre) begin
        repeat (dly) @(negedge clk);
        ack_a = 1;
      end
      @(negedge clk);
      ack_a = 0;
      check("idle_after_ack", int'({busy_a, a_if.result_valid}), 0);
    end
    ack_a = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit ok;
    int bad, nstop, n;
    logic prev;
    exp_t e;

    repeat (3) @(negedge clk);
    check("reset_outs", int'({start_a, stop_a, busy_a, a_if.result_valid, a_if.overflow}), 0);
    check("reset_result", int'(a_if.result), 0);
    rst_n = 1; ena = 1;
    @(negedge clk);

    do_meas(8'h07, 0, 0);          // 3 per conversion -> 12
    do_meas(8'h15, 1, 0);          // bubbles corrected -> 12
    do_meas(8'h00, 0, 2);          // 0
    do_meas(8'hFF, 0, 1);          // saturated -> 32, overflow
    check("ovf_sticky", int'(a_if.overflow), 1);
    do_meas(8'h01, 0, 0);          // overflow cleared, 4

    // Long ack hold: result stable, meas_req ignored, ack returns to IDLE.
    issue_a(8'h07);
    wait_valid_a(ok);
    if (ok) begin
      bad = 0;
      for (int i = 0; i < 50; i++) begin
        meas_req = (i == 10);
        if (a_if.result !== 6'd12 || !a_if.result_valid || !busy_a) bad++;
        @(negedge clk);
      end
      meas_req = 0;
      check("hold_stable", bad, 0);
      ack_a = 1;
      @(negedge clk);
      ack_a = 0;
      check("ack_to_idle", int'({busy_a, a_if.result_valid}), 0);
      repeat (5) @(negedge clk);
      check("req_ignored", int'(busy_a), 0);
    end

    for (int r = 0; r < 8; r++)
      do_meas(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));

    // ena drop during STOP of the second conversion.
    wait_idle();
    term = 8'h07;
    repeat (3) @(negedge clk);
    meas_req = 1;
    @(negedge clk);
    meas_req = 0;
    nstop = 0; n = 0; prev = stop_a;
    while (nstop < 2 && n < 200) begin
      @(negedge clk);
      if (stop_a && !prev) nstop++;
      prev = stop_a; n++;
    end
    check("second_stop_seen", nstop, 2);
    ena = 0;
    @(negedge clk);
    check("abort_edges", int'({start_a, stop_a, busy_a, a_if.result_valid}), 0);
    repeat (3) @(negedge clk);
    ena = 1;
    repeat (40) @(negedge clk);
    check("abort_idle", int'({busy_a, a_if.result_valid}), 0);

    // Async reset while in LAUNCH.
    meas_req = 1;
    @(negedge clk);
    meas_req = 0;
    check("in_launch", int'({start_a, stop_a}), 2);
    #2 rst_n = 0;
    #1 check("async_reset", int'({start_a, stop_a, busy_a, a_if.result_valid, a_if.overflow}), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Instance B (STOP_DLY=4), auto-acked.
    for (int k = 0; k < 2; k++) begin
      term = (k == 0) ? 8'h07 : 8'($urandom);
      repeat (3) @(negedge clk);
      e.res = ref_code(term) * NCONV; e.req_cyc = cyc;
      meas_req_b = 1;
      @(negedge clk);
      meas_req_b = 0;
      n = 0;
      while (!b_if.result_valid && n < 300) begin @(negedge clk); n++; end
      check("b_valid", int'(b_if.result_valid), 1);
      check("b_result", int'(b_if.result), e.res);
      check("b_latency", cyc - e.req_cyc, lat(SD_B));
      @(negedge clk);
      check("b_idle", int'(busy_b), 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
